// File: rtl/weight_stream_tx.sv
// Serialises one captured 5x5 weight filter into the 32-bit write stream of the weight row buffer.
// Build option: define WEIGHT_TX_BACK_TO_BACK_EN to accept a new frame on the last-word transfer edge.
module weight_stream_tx #(
   parameter int INPUT_WIDTH  = 32,
   parameter int OUTPUT_WIDTH = 32
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic                    LOAD_VALID,
   output logic                    LOAD_READY,
   input  logic [39:0]             LOAD_ROW_0,
   input  logic [39:0]             LOAD_ROW_1,
   input  logic [39:0]             LOAD_ROW_2,
   input  logic [39:0]             LOAD_ROW_3,
   input  logic [39:0]             LOAD_ROW_4,
   input  logic [3:0]              PARAM_R,
   input  logic [3:0]              PARAM_S,
   input  logic                    OUT_EN,
   output logic                    OUT_VALID,
   output logic [OUTPUT_WIDTH-1:0] OUT_DATA,
   output logic                    OUT_LAST,
   output logic                    DONE
);

   typedef enum logic {ST_IDLE, ST_SEND} state_t;

   state_t                  state_q, state_d;
   logic [199:0]            row_q;
   logic                    dense_q;
   logic [2:0]              n_q;
   logic [2:0]              idx_q;
   logic [OUTPUT_WIDTH-1:0] data_q;
   logic                    done_q;

   logic [199:0]            load_bus;
   logic [2:0]              r_eff;
   logic [2:0]              n_in;
   logic                    dense_in;
   logic                    in_send;
   logic                    is_last;
   logic                    accept;
   logic                    xfer;
   logic                    xfer_last;

   // Dense mode walks the 200-bit row concatenation in 32-bit steps; row mode takes the top 32 bits of each row.
   function automatic logic [INPUT_WIDTH-1:0] pick_word(input logic [199:0] rows,
                                                        input logic         dense,
                                                        input logic [2:0]   idx);
      logic [INPUT_WIDTH-1:0] w;
      w = '0;
      if (dense) begin
         case (idx)
            3'd0: w = rows[199:168];
            3'd1: w = rows[167:136];
            3'd2: w = rows[135:104];
            3'd3: w = rows[103:72];
            3'd4: w = rows[71:40];
            3'd5: w = rows[39:8];
            3'd6: w = {rows[7:0], 24'h0};
            default: w = '0;
         endcase
      end else begin
         case (idx)
            3'd0: w = rows[199:168];
            3'd1: w = rows[159:128];
            3'd2: w = rows[119:88];
            3'd3: w = rows[79:48];
            3'd4: w = rows[39:8];
            3'd5: w = rows[39:8];
            3'd6: w = {rows[7:0], 24'h0};
            default: w = '0;
         endcase
      end
      return w;
   endfunction

   assign load_bus = {LOAD_ROW_0, LOAD_ROW_1, LOAD_ROW_2, LOAD_ROW_3, LOAD_ROW_4};

   always_comb begin
      r_eff = PARAM_R[2:0];
      if (PARAM_R == 4'd0) begin
         r_eff = 3'd1;
      end else if (PARAM_R > 4'd5) begin
         r_eff = 3'd5;
      end
      dense_in = (PARAM_S >= 4'd5);
      n_in     = (dense_in || (r_eff == 3'd5)) ? 3'd7 : r_eff;
   end

   assign in_send   = (state_q == ST_SEND);
   assign is_last   = (idx_q == (n_q - 3'd1));
   assign OUT_VALID = in_send;
   assign OUT_LAST  = in_send & is_last;
   assign OUT_DATA  = data_q;
   assign DONE      = done_q;

`ifdef WEIGHT_TX_BACK_TO_BACK_EN
   assign LOAD_READY = (state_q == ST_IDLE) | (OUT_LAST & OUT_EN);
`else
   assign LOAD_READY = (state_q == ST_IDLE);
`endif

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      accept    = LOAD_VALID & LOAD_READY;
      xfer      = in_send & OUT_EN;
      xfer_last = xfer & is_last;
      case (state_q)
         ST_IDLE: if (accept) state_d = ST_SEND;
         ST_SEND: if (xfer_last && !accept) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // On accept, w0 is built straight from the load bus so it is registered in the same edge as the rows.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         row_q   <= '0;
         dense_q <= 1'b0;
         n_q     <= 3'd1;
         idx_q   <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= xfer_last;
         if (accept) begin
            row_q   <= load_bus;
            dense_q <= dense_in;
            n_q     <= n_in;
            idx_q   <= '0;
            data_q  <= pick_word(load_bus, dense_in, 3'd0);
         end else if (xfer) begin
            if (is_last) begin
               idx_q  <= '0;
               data_q <= '0;
            end else begin
               idx_q  <= idx_q + 3'd1;
               data_q <= pick_word(row_q, dense_q, idx_q + 3'd1);
            end
         end
      end
   end

endmodule

// File: tb/tb_weight_stream_tx.sv
// Self-checking bench for weight_stream_tx: vector table plus hand sequences for stall, reset and back-to-back.
module tb_weight_stream_tx;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        LOAD_VALID;
   logic        LOAD_READY;
   logic [39:0] LOAD_ROW_0, LOAD_ROW_1, LOAD_ROW_2, LOAD_ROW_3, LOAD_ROW_4;
   logic [3:0]  PARAM_R, PARAM_S;
   logic        OUT_EN;
   logic        OUT_VALID;
   logic [31:0] OUT_DATA;
   logic        OUT_LAST;
   logic        DONE;

   always #5 CLK = ~CLK;

   weight_stream_tx #(.INPUT_WIDTH(32), .OUTPUT_WIDTH(32)) dut (
      .CLK(CLK), .RESET(RESET), .LOAD_VALID(LOAD_VALID), .LOAD_READY(LOAD_READY),
      .LOAD_ROW_0(LOAD_ROW_0), .LOAD_ROW_1(LOAD_ROW_1), .LOAD_ROW_2(LOAD_ROW_2),
      .LOAD_ROW_3(LOAD_ROW_3), .LOAD_ROW_4(LOAD_ROW_4),
      .PARAM_R(PARAM_R), .PARAM_S(PARAM_S), .OUT_EN(OUT_EN), .OUT_VALID(OUT_VALID),
      .OUT_DATA(OUT_DATA), .OUT_LAST(OUT_LAST), .DONE(DONE)
   );

   typedef struct {
      logic [31:0] data;
      logic        first;
      logic        last;
   } exp_t;

   typedef struct {
      logic [3:0]  r;
      logic [3:0]  s;
      logic [39:0] rows [5];
      int unsigned en_mode;
      int          exp_n;
      logic [31:0] exp_first;
      logic [31:0] exp_final;
   } vec_t;

   exp_t        sb [$];
   int          checks = 0;
   int          passed = 0;
   int unsigned en_mode = 0;
   int          frame_cnt = 0;
   logic [31:0] frame_first = '0;
   logic [31:0] frame_final = '0;

   logic [39:0] asc [5] = '{40'h0001020304, 40'h0506070809, 40'h0A0B0C0D0E, 40'h0F10111213, 40'h1415161718};
   logic [39:0] abc [5] = '{40'hA0A1A2A3A4, 40'hB0B1B2B3B4, 40'hC0C1C2C3C4, 40'hD0D1D2D3D4, 40'hE0E1E2E3E4};
   logic [39:0] tp1 [5] = '{40'hAABBCCDD00, 40'h1122334400, 40'h5566778800, 40'h0, 40'h0};
   logic [39:0] one [5] = '{40'h123456789A, 40'h0, 40'h0, 40'h0, 40'h0};
   logic [39:0] fa  [5] = '{40'hCAFEF00D11, 40'h0, 40'h0, 40'h0, 40'h0};
   logic [39:0] fb  [5] = '{40'hBEEF123456, 40'h0, 40'h0, 40'h0, 40'h0};

   vec_t vecs [9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got %0h required %0h", name, act, req);
   endtask

   function automatic vec_t mk(input logic [3:0] r, input logic [3:0] s, input logic [39:0] rows [5],
                               input int unsigned m, input int n, input logic [31:0] f, input logic [31:0] l);
      vec_t v;
      v.r = r; v.s = s; v.rows = rows; v.en_mode = m;
      v.exp_n = n; v.exp_first = f; v.exp_final = l;
      return v;
   endfunction

   // Reference packing: dense mode shifts through {row0..row4, 24'h0}, row mode slices rows individually.
   function automatic void push_frame(input logic [3:0] r, input logic [3:0] s, input logic [39:0] rows [5]);
      int          reff, n;
      logic        dense;
      logic [223:0] big, tmp;
      exp_t        e;
      reff  = (r == 0) ? 1 : ((r > 5) ? 5 : int'(r));
      dense = (s >= 5);
      n     = (dense || reff == 5) ? 7 : reff;
      big   = {rows[0], rows[1], rows[2], rows[3], rows[4], 24'h0};
      for (int i = 0; i < n; i++) begin
         if (dense) begin
            tmp    = big >> (192 - 32 * i);
            e.data = tmp[31:0];
         end else if (i < 5) begin
            e.data = rows[i][39:8];
         end else if (i == 5) begin
            e.data = rows[4][39:8];
         end else begin
            e.data = {rows[4][7:0], 24'h0};
         end
         e.first = (i == 0);
         e.last  = (i == n - 1);
         sb.push_back(e);
      end
   endfunction

   task automatic drive_rows(input logic [3:0] r, input logic [3:0] s, input logic [39:0] rows [5]);
      LOAD_ROW_0 = rows[0]; LOAD_ROW_1 = rows[1]; LOAD_ROW_2 = rows[2];
      LOAD_ROW_3 = rows[3]; LOAD_ROW_4 = rows[4];
      PARAM_R = r; PARAM_S = s;
   endtask

   task automatic scramble_inputs();
      LOAD_ROW_0 = {$urandom, 8'h5A}; LOAD_ROW_1 = {$urandom, 8'hA5}; LOAD_ROW_2 = {$urandom, 8'h3C};
      LOAD_ROW_3 = {$urandom, 8'hC3}; LOAD_ROW_4 = {$urandom, 8'h99};
      PARAM_R = 4'($urandom_range(0, 15)); PARAM_S = 4'($urandom_range(0, 15));
   endtask

   task automatic load_frame(input logic [3:0] r, input logic [3:0] s, input logic [39:0] rows [5]);
      bit acc;
      acc = 0;
      @(posedge CLK); #1;
      drive_rows(r, s, rows);
      LOAD_VALID = 1'b1;
      for (int k = 0; k < 100 && !acc; k++) begin
         @(negedge CLK);
         if (LOAD_READY) begin
            push_frame(r, s, rows);
            acc = 1;
         end
      end
      if (!acc) begin
         checks++;
         $display("FAIL load_timeout: got LOAD_READY=0 for 100 cycles required 1");
      end
      @(posedge CLK); #1;
      LOAD_VALID = 1'b0;
      scramble_inputs();
   endtask

   task automatic wait_done();
      bit ok;
      ok = 0;
      for (int k = 0; k < 300 && !ok; k++) begin
         @(negedge CLK); #1;
         if (sb.size() == 0 && !OUT_VALID) ok = 1;
      end
      if (!ok) begin
         checks++;
         $display("FAIL frame_timeout: got %0d words pending required 0", sb.size());
      end
      @(negedge CLK);
   endtask

   // OUT_EN driver: 0 = held high, 1 = pattern 1,0,0 repeating, 2 = held low
   initial begin
      int unsigned cnt;
      cnt = 0;
      OUT_EN = 1'b1;
      forever begin
         @(posedge CLK); #2;
         case (en_mode)
            0: OUT_EN = 1'b1;
            1: OUT_EN = ((cnt % 3) == 0);
            default: OUT_EN = 1'b0;
         endcase
         cnt++;
      end
   end

   // Output monitor: scoreboard pop on transfer, DONE timing, stall stability, LOAD_READY during SEND.
   initial begin
      logic        done_exp, done_nxt, stall_prev, stall_last, ready_exp;
      logic [31:0] stall_data;
      exp_t        e;
      done_exp = 0; stall_prev = 0; stall_last = 0; stall_data = '0;
      forever begin
         @(negedge CLK);
         if (!RESET) begin
            check("done", DONE, done_exp);
            done_nxt = 0;
            if (stall_prev) begin
               check("valid_held", OUT_VALID, 1);
               check("hold_data", OUT_DATA, stall_data);
               check("hold_last", OUT_LAST, stall_last);
            end
            if (OUT_VALID) begin
`ifdef WEIGHT_TX_BACK_TO_BACK_EN
               ready_exp = (sb.size() > 0) && sb[0].last && OUT_EN;
`else
               ready_exp = 0;
`endif
               check("ready_in_send", LOAD_READY, ready_exp);
            end
            stall_prev = OUT_VALID && !OUT_EN;
            stall_data = OUT_DATA;
            stall_last = OUT_LAST;
            if (OUT_VALID && OUT_EN) begin
               if (sb.size() == 0) begin
                  checks++;
                  $display("FAIL unexpected_word: got %0h required no word", OUT_DATA);
               end else begin
                  e = sb.pop_front();
                  check("word", OUT_DATA, e.data);
                  check("last", OUT_LAST, e.last);
                  done_nxt = e.last;
                  if (e.first) frame_first = OUT_DATA;
                  frame_final = OUT_DATA;
                  frame_cnt++;
               end
            end
            done_exp = done_nxt;
         end else begin
            done_exp = 0;
            stall_prev = 0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish required finish before 500us");
      $fatal(1);
   end

   initial begin
      int   base, gap, fpos, lpos, exp_gap;
      int   stage;
      logic smp [$];

      vecs[0] = mk(4'd3, 4'd3, tp1, 0, 3, 32'hAABBCCDD, 32'h55667788);
      vecs[1] = mk(4'd5, 4'd5, asc, 0, 7, 32'h00010203, 32'h18000000);
      vecs[2] = mk(4'd5, 4'd3, abc, 0, 7, 32'hA0A1A2A3, 32'hE4000000);
      vecs[3] = mk(4'd5, 4'd5, asc, 1, 7, 32'h00010203, 32'h18000000);
      vecs[4] = mk(4'd0, 4'd2, one, 0, 1, 32'h12345678, 32'h12345678);
      vecs[5] = mk(4'd9, 4'd0, abc, 1, 7, 32'hA0A1A2A3, 32'hE4000000);
      vecs[6] = mk(4'd4, 4'd4, abc, 0, 4, 32'hA0A1A2A3, 32'hD0D1D2D3);
      vecs[7] = mk(4'd2, 4'd7, asc, 0, 7, 32'h00010203, 32'h18000000);
      vecs[8] = mk(4'd1, 4'd5, abc, 1, 7, 32'hA0A1A2A3, 32'hE4000000);

      RESET = 1'b1;
      LOAD_VALID = 1'b0;
      drive_rows(4'd0, 4'd0, one);
      #23;
      check("rst_ready", LOAD_READY, 1);
      check("rst_valid", OUT_VALID, 0);
      check("rst_data", OUT_DATA, 0);
      check("rst_last", OUT_LAST, 0);
      check("rst_done", DONE, 0);
      @(posedge CLK); #3;
      RESET = 1'b0;

      for (int v = 0; v < 9; v++) begin
         en_mode = vecs[v].en_mode;
         base = frame_cnt;
         load_frame(vecs[v].r, vecs[v].s, vecs[v].rows);
         wait_done();
         check($sformatf("v%0d_count", v), 64'(frame_cnt - base), 64'(vecs[v].exp_n));
         check($sformatf("v%0d_first", v), frame_first, vecs[v].exp_first);
         check($sformatf("v%0d_final", v), frame_final, vecs[v].exp_final);
      end

      // Reset with word 3 pending: stop consuming after three transfers, then reset mid-cycle.
      en_mode = 0;
      base = frame_cnt;
      load_frame(4'd5, 4'd5, asc);
      for (int k = 0; k < 50; k++) begin
         @(negedge CLK); #1;
         if (frame_cnt - base >= 3) break;
      end
      en_mode = 2;
      @(posedge CLK); #3;
      check("pre_rst_valid", OUT_VALID, 1);
      #1;
      RESET = 1'b1;
      #1;
      check("async_rst_valid", OUT_VALID, 0);
      check("async_rst_ready", LOAD_READY, 1);
      sb.delete();
      @(posedge CLK); @(posedge CLK); #3;
      RESET = 1'b0;
      #1;
      check("post_rst_ready", LOAD_READY, 1);
      check("post_rst_data", OUT_DATA, 0);
      check("post_rst_last", OUT_LAST, 0);
      en_mode = 0;
      base = frame_cnt;
      load_frame(4'd5, 4'd5, asc);
      wait_done();
      check("restart_count", 64'(frame_cnt - base), 64'd7);
      check("restart_first", frame_first, 32'h00010203);

      // Two single-word frames presented back-to-back.
      en_mode = 0;
      stage = 0;
      @(posedge CLK); #1;
      drive_rows(4'd1, 4'd1, fa);
      LOAD_VALID = 1'b1;
      for (int k = 0; k < 40 && stage < 2; k++) begin
         @(negedge CLK);
         if (stage > 0) smp.push_back(OUT_VALID);
         if (LOAD_READY) begin
            if (stage == 0) push_frame(4'd1, 4'd1, fa);
            else push_frame(4'd1, 4'd1, fb);
            stage++;
            @(posedge CLK); #1;
            if (stage == 1) drive_rows(4'd1, 4'd1, fb);
            else LOAD_VALID = 1'b0;
         end
      end
      if (stage < 2) begin
         checks++;
         $display("FAIL b2b_accept: got %0d frames accepted required 2", stage);
         LOAD_VALID = 1'b0;
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         smp.push_back(OUT_VALID);
      end
      fpos = -1; lpos = -1; gap = 0;
      foreach (smp[i]) if (smp[i]) begin
         if (fpos < 0) fpos = i;
         lpos = i;
      end
      for (int i = fpos + 1; i < lpos; i++) if (!smp[i]) gap++;
`ifdef WEIGHT_TX_BACK_TO_BACK_EN
      exp_gap = 0;
`else
      exp_gap = 1;
`endif
      check("b2b_gap", 64'(gap), 64'(exp_gap));
      wait_done();
      check("b2b_pending", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
